// File: rtl/memref_compare_sweep.sv
// memref_compare_sweep
//
// Post-run checker for the jacobi_2d HIR-vs-HLS comparison. Once both kernels
// have finished, a start pulse sweeps the two result memories in lock-step
// through their registered read ports and compares every word. The block
// reports a pass flag, the number of mismatching words and the lowest
// mismatching address. Results hold until the next accepted start.
//
// Optional build macro: CMP_TRACE_EN
//   When defined, adds first_mm_a_data / first_mm_b_data outputs that capture
//   both words at the first mismatch, plus a simulation-only message for every
//   mismatch seen. When undefined, those ports and messages are absent and all
//   other behaviour is identical.

module memref_compare_sweep #(
    parameter int WIDTH  = 32,
    parameter int SIZE   = 1024,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,

    output logic              a_rd_en,
    output logic [ADDR_W-1:0] a_rd_addr,
    input  logic [WIDTH-1:0]  a_rd_data,

    output logic              b_rd_en,
    output logic [ADDR_W-1:0] b_rd_addr,
    input  logic [WIDTH-1:0]  b_rd_data,

    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W:0]   mismatch_count,
    output logic              first_mm_valid,
    output logic [ADDR_W-1:0] first_mm_addr
`ifdef CMP_TRACE_EN
    ,
    output logic [WIDTH-1:0]  first_mm_a_data,
    output logic [WIDTH-1:0]  first_mm_b_data
`endif
);

    // Mismatch counter is one bit wider than the address so it can hold SIZE.
    localparam int CNT_W = ADDR_W + 1;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SIZE - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SWEEP = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;

    // Compare pipeline: a valid bit and the address that goes with the
    // read data arriving this cycle.
    logic                valid_q, valid_d;
    logic [ADDR_W-1:0]   vaddr_q, vaddr_d;

    // Result registers.
    logic [CNT_W-1:0]    count_q, count_d;
    logic                pass_q, pass_d;
    logic                fmValid_q, fmValid_d;
    logic [ADDR_W-1:0]   fmAddr_q, fmAddr_d;

`ifdef CMP_TRACE_EN
    logic [WIDTH-1:0]    fmAData_q, fmAData_d;
    logic [WIDTH-1:0]    fmBData_q, fmBData_d;
`endif

    logic                startAccept;
    logic                mismatch;

    // A start is only honoured while idle; anything else is dropped.
    assign startAccept = (state_q == S_IDLE) && start;

    // Data ports are only meaningful while the compare valid is set.
    assign mismatch = valid_q && (a_rd_data != b_rd_data);

    // Sweep controller: walks the address from 0 to SIZE-1, then drains the
    // final compare and signals completion for one cycle.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_SWEEP;
                    addr_d  = '0;
                end
            end
            S_SWEEP: begin
                if (addr_q == LAST_ADDR) begin
                    state_d = S_DRAIN;
                end else begin
                    addr_d = addr_q + ADDR_ONE;
                end
            end
            S_DRAIN: begin
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Controller state and read address, cleared asynchronously so the read
    // enables drop the moment reset is asserted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    // Compare and result bookkeeping: clear on an accepted start, count each
    // mismatch, latch the first one, and settle the pass flag as the final
    // compare is folded in during the drain cycle.
    always_comb begin
        valid_d   = (state_q == S_SWEEP);
        vaddr_d   = addr_q;
        count_d   = count_q;
        pass_d    = pass_q;
        fmValid_d = fmValid_q;
        fmAddr_d  = fmAddr_q;
`ifdef CMP_TRACE_EN
        fmAData_d = fmAData_q;
        fmBData_d = fmBData_q;
`endif

        if (startAccept) begin
            count_d   = '0;
            pass_d    = 1'b0;
            fmValid_d = 1'b0;
            fmAddr_d  = '0;
`ifdef CMP_TRACE_EN
            fmAData_d = '0;
            fmBData_d = '0;
`endif
        end

        if (mismatch) begin
            count_d = count_q + CNT_ONE;
            if (!fmValid_q) begin
                fmValid_d = 1'b1;
                fmAddr_d  = vaddr_q;
`ifdef CMP_TRACE_EN
                fmAData_d = a_rd_data;
                fmBData_d = b_rd_data;
`endif
            end
        end

        if (state_q == S_DRAIN) begin
            pass_d = (count_d == '0);
        end
    end

    // Compare pipeline and result registers; an in-flight compare is simply
    // discarded by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q   <= 1'b0;
            vaddr_q   <= '0;
            count_q   <= '0;
            pass_q    <= 1'b0;
            fmValid_q <= 1'b0;
            fmAddr_q  <= '0;
`ifdef CMP_TRACE_EN
            fmAData_q <= '0;
            fmBData_q <= '0;
`endif
        end else begin
            valid_q   <= valid_d;
            vaddr_q   <= vaddr_d;
            count_q   <= count_d;
            pass_q    <= pass_d;
            fmValid_q <= fmValid_d;
            fmAddr_q  <= fmAddr_d;
`ifdef CMP_TRACE_EN
            fmAData_q <= fmAData_d;
            fmBData_q <= fmBData_d;
`endif
        end
    end

    assign a_rd_en        = (state_q == S_SWEEP);
    assign b_rd_en        = (state_q == S_SWEEP);
    assign a_rd_addr      = addr_q;
    assign b_rd_addr      = addr_q;
    assign busy           = (state_q == S_SWEEP) || (state_q == S_DRAIN);
    assign done           = (state_q == S_DONE);
    assign pass           = pass_q;
    assign mismatch_count = count_q;
    assign first_mm_valid = fmValid_q;
    assign first_mm_addr  = fmAddr_q;

`ifdef CMP_TRACE_EN
    assign first_mm_a_data = fmAData_q;
    assign first_mm_b_data = fmBData_q;

`ifndef SYNTHESIS
    // Simulation-only trace of every mismatching word pair.
    always @(posedge clk) begin
        if (rst && mismatch) begin
            $display("memref_compare_sweep: mismatch addr=%0d A=%h B=%h",
                     vaddr_q, a_rd_data, b_rd_data);
        end
    end
`endif
`endif

endmodule
